rv32_clint: RTL and testbench
=============================

RV32_CLINT -- requirements
Module: rv32_clint

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 1, number of hart channels (1..8).
REQ-002 SHALL have parameter MTIME_WIDTH, default 64, mtime counter width (33..64).
REQ-003 SHALL have parameter PRESCALE, default 1, clk_in cycles per mtime tick (1..256).
REQ-004 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port halt_in  input  1  freezes the mtime and prescaler counting while high.
REQ-007 SHALL have port psel_in / penable_in / pwrite_in  input  1 each  APB slave control.
REQ-008 SHALL have port paddr_in  input  16  APB byte address; bits [1:0] are ignored.
REQ-009 SHALL have port pwdata_in  input  32  APB write data.
REQ-010 SHALL have port prdata_out  output  32  APB read data, registered.
REQ-011 SHALL have port pready_out  output  1  APB ready.
REQ-012 SHALL have port pslverr_out  output  1  APB error, unmapped address.
REQ-013 SHALL have port mtime_out  output  64  mtime zero-extended; drives the core riscv32_mp_rc_in.
REQ-014 SHALL have port tirq_out  output  NUM_HARTS  per-hart timer interrupt, drives riscv32_mp_tirq_in.
REQ-015 SHALL have port sirq_out  output  NUM_HARTS  per-hart software interrupt, drives riscv32_mp_sirq_in.

Function
REQ-016 SHALL map the registers as follows: msip[h] at 0x0000+4h (bit0 only), mtimecmp[h] lo/hi at 0x4000+8h / 0x4004+8h, mtime lo/hi at 0xBFF8 / 0xBFFC.
REQ-017 SHALL use an APB setup phase (psel=1, penable=0) followed by an access phase (psel=1, penable=1); the access phase completes in 1 cycle with zero wait states: pready_out=1 combinationally when psel&penable, 0 otherwise.
REQ-018 SHALL commit writes at the access-phase clock edge and load prdata_out at the setup-phase clock edge, so prdata_out is valid throughout the access phase.
REQ-019 SHALL assert pslverr_out with pready_out for an unmapped address or a hart index >= NUM_HARTS; such writes have no effect and such reads return 0.
REQ-020 SHALL keep a prescaler that counts 0..PRESCALE-1 while halt_in=0; on the wrap to 0 it generates a tick that increments mtime by 1.
REQ-021 SHALL wrap mtime modulo 2^MTIME_WIDTH (all-ones -> 0) with no flag; bits above MTIME_WIDTH read 0 and ignore writes.
REQ-022 SHALL give an APB write to either mtime half priority over a coincident tick; the written half takes pwdata, the other half holds, and the prescaler resets to 0.
REQ-023 SHALL copy mtime[63:32] into a shadow register when mtime lo is read; a read of mtime hi returns the shadow, giving an atomic 64-bit read via a lo-then-hi sequence.
REQ-024 SHALL register tirq_out[h] one cycle after the comparison (mtime >= mtimecmp[h], unsigned, full width) becomes true or false, including after an mtimecmp write.
REQ-025 SHALL set sirq_out[h] equal to msip[h] (registered bit, no extra latency).
REQ-026 SHALL have halt_in freeze both mtime and the prescaler value; APB access and comparison stay active while halted.

Reset
REQ-027 SHALL, on rst_in, set mtime=0, prescaler=0, shadow=0, msip=0, all mtimecmp=all-ones, tirq_out=0, sirq_out=0, prdata_out=0, pslverr_out=0, with no clock required.
REQ-028 SHALL, if reset asserts mid-transfer, drop the transfer; the first transfer after deassertion behaves normally.

Verification
REQ-029 SHALL check this scenario: PRESCALE=4, reset released -> mtime_out=1 after 4 clocks and 5 after 20 clocks; halt_in high for 8 clocks -> value unchanged.
REQ-030 SHALL check this scenario: NUM_HARTS=2, write mtimecmp[1] lo=0x10 and hi=0 -> tirq_out=2'b10 exactly one cycle after mtime reaches 0x10; write lo=0xFFFFFFFF -> tirq_out[1]=0 next cycle.
REQ-031 SHALL check this scenario: mtime=0x0000_0000_FFFF_FFFF at the lo read, tick before the hi read -> hi read returns 0x0, not 0x1.
REQ-032 SHALL check this scenario: MTIME_WIDTH=40, write lo=0xFFFFFFFF and hi=0xFF -> next tick gives mtime_out=0; a read of hi returns 0.
REQ-033 SHALL check this scenario: write 1 to msip at 0x0004 with NUM_HARTS=1 -> pslverr_out=1 and sirq_out unchanged; write 1 at 0x0000 -> sirq_out[0]=1 next cycle.
REQ-034 SHALL check this scenario: mtime lo write in the same cycle as a tick -> mtime lo equals pwdata and the prescaler restarts from 0.

Source files
------------

// File: rtl/rv32_clint_if.sv
// rv32_clint_if -- APB slave bus bundle for the RISC-V core-local interruptor.
//
// Signals (names follow the CLINT pin list; _in = towards the CLINT):
//   psel_in, penable_in, pwrite_in : APB control
//   paddr_in  [15:0]               : byte address, bits [1:0] ignored
//   pwdata_in [31:0]               : write data
//   prdata_out[31:0]               : registered read data
//   pready_out                     : ready, high during the access phase
//   pslverr_out                    : error for unmapped addresses
// Modports: master drives control/address/data, slave drives the responses.
interface rv32_clint_if;
   logic        psel_in;
   logic        penable_in;
   logic        pwrite_in;
   logic [15:0] paddr_in;
   logic [31:0] pwdata_in;
   logic [31:0] prdata_out;
   logic        pready_out;
   logic        pslverr_out;

   modport master (
      output psel_in, penable_in, pwrite_in, paddr_in, pwdata_in,
      input  prdata_out, pready_out, pslverr_out
   );

   modport slave (
      input  psel_in, penable_in, pwrite_in, paddr_in, pwdata_in,
      output prdata_out, pready_out, pslverr_out
   );
endinterface

// File: rtl/rv32_clint.sv
// rv32_clint -- core-local interruptor: free-running mtime with prescaler,
// per-hart mtimecmp compare (timer irq) and msip bits (software irq),
// all reachable over a zero-wait-state APB slave.
//
// Ports:
//   clk_in     : single clock, all state on its rising edge
//   rst_in     : asynchronous active-high reset
//   halt_in    : freezes mtime and the prescaler while high
//   apb        : APB slave bundle (rv32_clint_if.slave)
//   mtime_out  : mtime zero-extended to 64 bits
//   tirq_out   : per-hart timer interrupt (mtime >= mtimecmp, one cycle late)
//   sirq_out   : per-hart software interrupt (msip bit)
//
// Register map: msip[h] 0x0000+4h, mtimecmp[h] 0x4000+8h (lo) / +4 (hi),
// mtime 0xBFF8 (lo) / 0xBFFC (hi). Reading mtime lo snapshots mtime hi into
// a shadow which the following hi read returns, so lo-then-hi is atomic.
module rv32_clint #(
   parameter int NUM_HARTS   = 1,
   parameter int MTIME_WIDTH = 64,
   parameter int PRESCALE    = 1
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 halt_in,
   rv32_clint_if.slave          apb,
   output logic [63:0]          mtime_out,
   output logic [NUM_HARTS-1:0] tirq_out,
   output logic [NUM_HARTS-1:0] sirq_out
);
   localparam int                     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0]        PS_LAST = PS_W'(PRESCALE - 1);
   localparam logic [PS_W-1:0]        PS_ONE  = PS_W'(32'd1);
   localparam logic [PS_W-1:0]        PS_ZERO = {PS_W{1'b0}};
   localparam logic [MTIME_WIDTH-1:0] MT_ONE  = MTIME_WIDTH'(32'd1);
   localparam logic [63:0]            CMP_RST = {64{1'b1}};

   logic [MTIME_WIDTH-1:0]      mtime_q, mtime_d;
   logic [PS_W-1:0]             presc_q, presc_d;
   logic [31:0]                 shadow_q, shadow_d;
   logic [NUM_HARTS-1:0]        msip_q, msip_d;
   logic [NUM_HARTS-1:0][63:0]  cmp_q, cmp_d;
   logic [NUM_HARTS-1:0]        tirq_q, tirq_d;
   logic [31:0]                 prdata_q, prdata_d;
   logic                        pslverr_q, pslverr_d;

   logic        setup_s, access_s, wr_s, rd_setup_s;
   logic        sel_msip_s, sel_cmp_s, sel_mtime_s, half_s, hart_ok_s, map_ok_s;
   logic [2:0]  hart_s;
   logic [63:0] mtime_ext_s;
   logic [31:0] rd_val_s;
   logic [1:0]  unused_addr_s;

   assign unused_addr_s = apb.paddr_in[1:0];

   // Address decode, hart range check and read-data mux.
   always_comb begin
      setup_s     = apb.psel_in & ~apb.penable_in;
      access_s    = apb.psel_in & apb.penable_in;
      sel_msip_s  = 1'b0;
      sel_cmp_s   = 1'b0;
      sel_mtime_s = 1'b0;
      hart_s      = 3'd0;
      half_s      = apb.paddr_in[2];
      if (apb.paddr_in[15:5] == 11'h000) begin
         sel_msip_s = 1'b1;
         hart_s     = apb.paddr_in[4:2];
      end else if (apb.paddr_in[15:6] == 10'h100) begin
         sel_cmp_s = 1'b1;
         hart_s    = apb.paddr_in[5:3];
      end else if (apb.paddr_in[15:3] == 13'h17FF) begin
         sel_mtime_s = 1'b1;
      end else begin
         sel_mtime_s = 1'b0;
      end
      mtime_ext_s                    = 64'd0;
      mtime_ext_s[MTIME_WIDTH-1:0]   = mtime_q;
      // mtime hi always comes from the shadow captured by the last lo read
      rd_val_s  = sel_mtime_s ? (half_s ? shadow_q : mtime_ext_s[31:0]) : 32'd0;
      hart_ok_s = 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) begin
         hart_ok_s = hart_ok_s | (hart_s == 3'(i));
         rd_val_s  = rd_val_s |
                     ((sel_msip_s && (hart_s == 3'(i))) ? {31'd0, msip_q[i]} : 32'd0);
         rd_val_s  = rd_val_s |
                     ((sel_cmp_s && (hart_s == 3'(i))) ?
                      (half_s ? cmp_q[i][63:32] : cmp_q[i][31:0]) : 32'd0);
      end
      map_ok_s   = sel_mtime_s | ((sel_msip_s | sel_cmp_s) & hart_ok_s);
      wr_s       = access_s & apb.pwrite_in & map_ok_s;
      rd_setup_s = setup_s & ~apb.pwrite_in;
   end

   // mtime / prescaler next state; a bus write to mtime beats a coincident tick.
   always_comb begin
      mtime_d = mtime_q;
      presc_d = presc_q;
      if (wr_s && sel_mtime_s && !half_s) begin
         mtime_d[31:0] = apb.pwdata_in;
         presc_d       = PS_ZERO;
      end else if (wr_s && sel_mtime_s) begin
         mtime_d[MTIME_WIDTH-1:32] = apb.pwdata_in[MTIME_WIDTH-33:0];
         presc_d                   = PS_ZERO;
      end else if (halt_in) begin
         mtime_d = mtime_q;
         presc_d = presc_q;
      end else if (presc_q == PS_LAST) begin
         mtime_d = mtime_q + MT_ONE;
         presc_d = PS_ZERO;
      end else begin
         presc_d = presc_q + PS_ONE;
      end
   end

   // Register writes (access edge), read capture and error flag (setup edge), compare.
   always_comb begin
      msip_d    = msip_q;
      cmp_d     = cmp_q;
      tirq_d    = {NUM_HARTS{1'b0}};
      shadow_d  = shadow_q;
      prdata_d  = prdata_q;
      pslverr_d = 1'b0;
      for (int i = 0; i < NUM_HARTS; i++) begin
         msip_d[i] = (wr_s && sel_msip_s && (hart_s == 3'(i))) ? apb.pwdata_in[0] : msip_q[i];
         if (wr_s && sel_cmp_s && (hart_s == 3'(i))) begin
            if (half_s) begin
               cmp_d[i][63:32] = apb.pwdata_in;
            end else begin
               cmp_d[i][31:0] = apb.pwdata_in;
            end
         end else begin
            cmp_d[i] = cmp_q[i];
         end
         tirq_d[i] = (mtime_ext_s >= cmp_q[i]);
      end
      // error is captured at setup so it is registered yet aligned with pready
      if (setup_s) begin
         pslverr_d = ~map_ok_s;
         if (rd_setup_s) begin
            prdata_d = map_ok_s ? rd_val_s : 32'd0;
         end else begin
            prdata_d = prdata_q;
         end
         if (rd_setup_s && sel_mtime_s && !half_s) begin
            shadow_d = mtime_ext_s[63:32];
         end else begin
            shadow_d = shadow_q;
         end
      end else begin
         pslverr_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         mtime_q   <= {MTIME_WIDTH{1'b0}};
         presc_q   <= PS_ZERO;
         shadow_q  <= 32'd0;
         msip_q    <= {NUM_HARTS{1'b0}};
         cmp_q     <= {NUM_HARTS{CMP_RST}};
         tirq_q    <= {NUM_HARTS{1'b0}};
         prdata_q  <= 32'd0;
         pslverr_q <= 1'b0;
      end else begin
         mtime_q   <= mtime_d;
         presc_q   <= presc_d;
         shadow_q  <= shadow_d;
         msip_q    <= msip_d;
         cmp_q     <= cmp_d;
         tirq_q    <= tirq_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   assign mtime_out       = mtime_ext_s;
   assign tirq_out        = tirq_q;
   assign sirq_out        = msip_q;
   assign apb.prdata_out  = prdata_q;
   assign apb.pslverr_out = pslverr_q;
   assign apb.pready_out  = access_s;
endmodule

// File: tb/tb_rv32_clint.sv
// Testbench for rv32_clint. Two instances share clock, reset and halt:
//   dut_a : NUM_HARTS=2, MTIME_WIDTH=40, PRESCALE=4
//   dut_b : NUM_HARTS=1, MTIME_WIDTH=64, PRESCALE=1
// APB response expectations are queued when a transfer is driven and popped
// in the access phase, where the DUT presents its response.
module tb_rv32_clint;
   logic clk  = 1'b0;
   logic rst  = 1'b0;
   logic halt = 1'b0;

   always #5 clk = ~clk;

   rv32_clint_if apb_a ();
   rv32_clint_if apb_b ();

   logic [63:0] mtime_a, mtime_b;
   logic [1:0]  tirq_a, sirq_a;
   logic [0:0]  tirq_b, sirq_b;

   rv32_clint #(.NUM_HARTS(2), .MTIME_WIDTH(40), .PRESCALE(4)) dut_a (
      .clk_in(clk), .rst_in(rst), .halt_in(halt), .apb(apb_a),
      .mtime_out(mtime_a), .tirq_out(tirq_a), .sirq_out(sirq_a)
   );

   rv32_clint #(.NUM_HARTS(1), .MTIME_WIDTH(64), .PRESCALE(1)) dut_b (
      .clk_in(clk), .rst_in(rst), .halt_in(halt), .apb(apb_b),
      .mtime_out(mtime_b), .tirq_out(tirq_b), .sirq_out(sirq_b)
   );

   typedef struct {
      logic        err;
      logic        is_rd;
      logic [31:0] data;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_bus(input bit s, input logic sel, input logic en, input logic wr,
                          input logic [15:0] addr, input logic [31:0] wd);
      if (!s) begin
         apb_a.psel_in = sel; apb_a.penable_in = en; apb_a.pwrite_in = wr;
         apb_a.paddr_in = addr; apb_a.pwdata_in = wd;
      end else begin
         apb_b.psel_in = sel; apb_b.penable_in = en; apb_b.pwrite_in = wr;
         apb_b.paddr_in = addr; apb_b.pwdata_in = wd;
      end
   endtask

   task automatic sample(input bit s, output logic rdy, output logic err, output logic [31:0] rd);
      if (!s) begin
         rdy = apb_a.pready_out; err = apb_a.pslverr_out; rd = apb_a.prdata_out;
      end else begin
         rdy = apb_b.pready_out; err = apb_b.pslverr_out; rd = apb_b.prdata_out;
      end
   endtask

   // Called just after a rising edge; returns just after the access-phase edge.
   task automatic apb_xfer(input bit s, input logic wr, input logic [15:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input string tag);
      exp_t        e;
      logic        rdy, err;
      logic [31:0] rd;
      e.err = exp_err; e.is_rd = ~wr; e.data = exp_rd; e.tag = tag;
      sb_q.push_back(e);
      set_bus(s, 1'b1, 1'b0, wr, addr, wd);
      @(negedge clk);
      sample(s, rdy, err, rd);
      check_eq({tag, "_setup_rdy"}, {63'd0, rdy}, 64'd0);
      @(posedge clk); #1;
      set_bus(s, 1'b1, 1'b1, wr, addr, wd);
      @(negedge clk);
      e = sb_q.pop_front();
      sample(s, rdy, err, rd);
      check_eq({e.tag, "_rdy"}, {63'd0, rdy}, 64'd1);
      check_eq({e.tag, "_err"}, {63'd0, err}, {63'd0, e.err});
      if (e.is_rd) check_eq({e.tag, "_rdata"}, {32'd0, rd}, {32'd0, e.data});
      @(posedge clk); #1;
      set_bus(s, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
   endtask

   task automatic apb_wr(input bit s, input logic [15:0] addr, input logic [31:0] wd,
                         input logic exp_err, input string tag);
      apb_xfer(s, 1'b1, addr, wd, 32'h0000_0000, exp_err, tag);
   endtask

   task automatic apb_rd(input bit s, input logic [15:0] addr, input logic [31:0] exp_rd,
                         input logic exp_err, input string tag);
      apb_xfer(s, 1'b0, addr, 32'h0000_0000, exp_rd, exp_err, tag);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      set_bus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
      set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
      #1 rst = 1'b1;
      #2;
      // reset values before any clock edge
      check_eq("rst_mtime_a", mtime_a, 64'd0);
      check_eq("rst_mtime_b", mtime_b, 64'd0);
      check_eq("rst_tirq_a", {62'd0, tirq_a}, 64'd0);
      check_eq("rst_sirq_a", {62'd0, sirq_a}, 64'd0);
      check_eq("rst_prdata_a", {32'd0, apb_a.prdata_out}, 64'd0);
      check_eq("rst_pslverr_a", {63'd0, apb_a.pslverr_out}, 64'd0);
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b0;

      // prescaler 4: one tick every 4 clocks; halt freezes count and prescaler
      step(4);
      check_eq("ps_mtime_4clk", mtime_a, 64'd1);
      check_eq("ps1_mtime_4clk", mtime_b, 64'd4);
      step(16);
      check_eq("ps_mtime_20clk", mtime_a, 64'd5);
      check_eq("ps1_mtime_20clk", mtime_b, 64'd20);
      halt = 1'b1;
      step(8);
      check_eq("halt_mtime_a", mtime_a, 64'd5);
      check_eq("halt_mtime_b", mtime_b, 64'd20);
      halt = 1'b0;
      step(3);
      check_eq("unhalt_3clk", mtime_a, 64'd5);
      step(1);
      check_eq("unhalt_4clk", mtime_a, 64'd6);

      // timer interrupt on hart 1 of dut_a
      apb_wr(1'b0, 16'h400C, 32'h0000_0000, 1'b0, "cmp1_hi_wr");
      apb_wr(1'b0, 16'h4008, 32'h0000_0010, 1'b0, "cmp1_lo_wr");
      apb_wr(1'b0, 16'hBFF8, 32'h0000_000E, 1'b0, "mtime_lo_0e");
      check_eq("tirq_before", {62'd0, tirq_a}, 64'd0);
      step(8);
      check_eq("mtime_reach_10", mtime_a, 64'h10);
      check_eq("tirq_same_cycle", {62'd0, tirq_a}, 64'd0);
      step(1);
      check_eq("tirq_next_cycle", {62'd0, tirq_a}, 64'd2);
      apb_wr(1'b0, 16'h4008, 32'hFFFF_FFFF, 1'b0, "cmp1_lo_ff");
      check_eq("tirq_hold", {62'd0, tirq_a}, 64'd2);
      step(1);
      check_eq("tirq_clear", {62'd0, tirq_a}, 64'd0);
      apb_rd(1'b0, 16'h4008, 32'hFFFF_FFFF, 1'b0, "cmp1_lo_rd");
      apb_rd(1'b0, 16'h400C, 32'h0000_0000, 1'b0, "cmp1_hi_rd");
      apb_rd(1'b0, 16'h4004, 32'hFFFF_FFFF, 1'b0, "cmp0_hi_rd");
      apb_wr(1'b0, 16'h4010, 32'h0000_0000, 1'b1, "cmp2_wr_err");
      apb_rd(1'b0, 16'h4014, 32'h0000_0000, 1'b1, "cmp2_rd_err");
      check_eq("tirq_after_err", {62'd0, tirq_a}, 64'd0);

      // atomic lo/hi read across a carry into the high word
      apb_wr(1'b0, 16'hBFFC, 32'h0000_0000, 1'b0, "mtime_hi_0");
      apb_wr(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 1'b0, "mtime_lo_ff");
      apb_rd(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 1'b0, "atom_lo");
      step(2);
      check_eq("atom_carry", mtime_a, 64'h1_0000_0000);
      apb_rd(1'b0, 16'hBFFC, 32'h0000_0000, 1'b0, "atom_hi_shadow");
      apb_rd(1'b0, 16'hBFF8, 32'h0000_0000, 1'b0, "atom_lo2");
      apb_rd(1'b0, 16'hBFFC, 32'h0000_0001, 1'b0, "atom_hi2");

      // 40-bit wrap and masking of the unimplemented high bits
      apb_wr(1'b0, 16'hBFF8, 32'hFFFF_FFFF, 1'b0, "w40_lo");
      apb_wr(1'b0, 16'hBFFC, 32'h0000_00FF, 1'b0, "w40_hi");
      check_eq("w40_max", mtime_a, 64'hFF_FFFF_FFFF);
      step(3);
      check_eq("w40_max_hold", mtime_a, 64'hFF_FFFF_FFFF);
      step(1);
      check_eq("w40_wrap", mtime_a, 64'd0);
      apb_rd(1'b0, 16'hBFF8, 32'h0000_0000, 1'b0, "w40_lo_rd");
      apb_rd(1'b0, 16'hBFFC, 32'h0000_0000, 1'b0, "w40_hi_rd");
      apb_wr(1'b0, 16'hBFFC, 32'hABCD_EF12, 1'b0, "w40_hi_mask");
      check_eq("w40_mask_val", mtime_a, 64'h12_0000_0001);
      apb_rd(1'b0, 16'hBFF8, 32'h0000_0001, 1'b0, "w40_lo_rd2");
      apb_rd(1'b0, 16'hBFFC, 32'h0000_0012, 1'b0, "w40_hi_rd2");

      // write coincident with a tick, then prescaler restart
      apb_wr(1'b0, 16'hBFF8, 32'h0000_0100, 1'b0, "ps_w1");
      step(2);
      apb_wr(1'b0, 16'hBFF8, 32'h0000_0055, 1'b0, "ps_w2_tick");
      check_eq("wr_beats_tick", {32'd0, mtime_a[31:0]}, 64'h55);
      apb_wr(1'b0, 16'hBFF8, 32'h0000_0200, 1'b0, "ps_w3");
      check_eq("ps_restart_0", {32'd0, mtime_a[31:0]}, 64'h200);
      step(3);
      check_eq("ps_restart_3", {32'd0, mtime_a[31:0]}, 64'h200);
      step(1);
      check_eq("ps_restart_4", {32'd0, mtime_a[31:0]}, 64'h201);

      // software interrupt and decode errors on single-hart dut_b
      apb_wr(1'b1, 16'h0004, 32'h0000_0001, 1'b1, "msip1_err");
      check_eq("sirq_unchanged", {63'd0, sirq_b}, 64'd0);
      apb_wr(1'b1, 16'h0000, 32'h0000_0001, 1'b0, "msip0_wr");
      check_eq("sirq_set", {63'd0, sirq_b}, 64'd1);
      apb_rd(1'b1, 16'h0000, 32'h0000_0001, 1'b0, "msip0_rd");
      apb_rd(1'b1, 16'h0004, 32'h0000_0000, 1'b1, "msip1_rd_err");
      apb_rd(1'b1, 16'h8000, 32'h0000_0000, 1'b1, "unmapped_rd");
      apb_rd(1'b1, 16'h4000, 32'hFFFF_FFFF, 1'b0, "b_cmp0_lo_rst");
      apb_rd(1'b1, 16'h4008, 32'h0000_0000, 1'b1, "b_cmp1_err");
      apb_wr(1'b1, 16'h4004, 32'h0000_0000, 1'b0, "b_cmp0_hi");
      apb_wr(1'b1, 16'h4000, 32'h0000_0000, 1'b0, "b_cmp0_lo");
      check_eq("b_tirq_lag", {63'd0, tirq_b}, 64'd0);
      step(1);
      check_eq("b_tirq_set", {63'd0, tirq_b}, 64'd1);

      // reset in the middle of a transfer
      set_bus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 32'h0000_0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_sirq_b", {63'd0, sirq_b}, 64'd0);
      check_eq("mid_rst_tirq_b", {63'd0, tirq_b}, 64'd0);
      check_eq("mid_rst_mtime_b", mtime_b, 64'd0);
      check_eq("mid_rst_mtime_a", mtime_a, 64'd0);
      check_eq("mid_rst_pslverr_b", {63'd0, apb_b.pslverr_out}, 64'd0);
      check_eq("mid_rst_prdata_b", {32'd0, apb_b.prdata_out}, 64'd0);
      @(posedge clk); #1;
      set_bus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0000_0000);
      @(posedge clk); #1;
      rst = 1'b0;
      apb_rd(1'b0, 16'hBFF8, 32'h0000_0000, 1'b0, "post_rst_mtime_a");
      apb_rd(1'b1, 16'h0000, 32'h0000_0000, 1'b0, "post_rst_msip_b");
      apb_rd(1'b1, 16'h4000, 32'hFFFF_FFFF, 1'b0, "post_rst_cmp_b");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
